// File: rtl/sram_arbiter_if.sv
// Bundle of request, response and memory-side signals around the SRAM arbiter.
// The arbiter connects through the slave modport; the requesters and the
// mapping stage (or a testbench standing in for them) use the master modport.
interface sram_arbiter_if;

   // CPU requester: read/write with ramdisk page
   logic        cpu_req;
   logic        cpu_wr;
   logic [15:0] cpu_addr;
   logic [2:0]  cpu_page;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;

   // Video fetcher: read-only, always page 0
   logic        vid_req;
   logic [15:0] vid_addr;
   logic [7:0]  vid_rdata;
   logic        vid_ack;

   // Byte bus towards the mapping stage
   logic [15:0] mem_abus;
   logic [2:0]  mem_page;
   logic [7:0]  mem_dout;
   logic        mem_memwr_n;
   logic [7:0]  mem_din;

   // Arbiter status
   logic        busy;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_page, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  vid_req, vid_addr,
      output vid_rdata, vid_ack,
      output mem_abus, mem_page, mem_dout, mem_memwr_n,
      input  mem_din,
      output busy
   );

   // Requester / memory side
   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_page, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output vid_req, vid_addr,
      input  vid_rdata, vid_ack,
      input  mem_abus, mem_page, mem_dout, mem_memwr_n,
      output mem_din,
      input  busy
   );

endinterface : sram_arbiter_if

// File: rtl/sram_arbiter.sv
// Two-way SRAM byte-bus arbiter: CPU (read/write, paged) and video (read-only).
// Every output is a flop loaded from the next-state logic, so the mapping
// stage sees glitch-free address/page/data/strobe and no input reaches an
// output combinationally. Writes get one setup cycle, WR_CYCLES strobe-low
// cycles and one hold cycle; reads hold the address RD_CYCLES cycles before
// sampling mem_din. Each completion is signalled by a single-cycle ack in DONE.
module sram_arbiter #(
   parameter int unsigned RD_CYCLES = 2,   // legal range 1..15
   parameter int unsigned WR_CYCLES = 2    // legal range 1..15
) (
   input  logic           clk,
   input  logic           reset_n,
   sram_arbiter_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR_SETUP,
      S_WR_STROBE,
      S_WR_HOLD,
      S_DONE
   } state_t;

   // Counter start values: the counter runs down to zero inclusive, so the
   // phase lasts (start + 1) cycles.
   localparam logic [3:0] RD_CNT_INIT = 4'(RD_CYCLES - 1);
   localparam logic [3:0] WR_CNT_INIT = 4'(WR_CYCLES - 1);

   // Control state
   state_t      state_q,       state_d;
   logic [3:0]  cnt_q,         cnt_d;
   logic        grant_vid_q,   grant_vid_d;    // current transaction owner
   logic        last_vid_q,    last_vid_d;     // last grant went to video

   // Registered outputs
   logic [15:0] mem_abus_q,    mem_abus_d;
   logic [2:0]  mem_page_q,    mem_page_d;
   logic [7:0]  mem_dout_q,    mem_dout_d;
   logic        mem_memwr_n_q, mem_memwr_n_d;
   logic [7:0]  cpu_rdata_q,   cpu_rdata_d;
   logic [7:0]  vid_rdata_q,   vid_rdata_d;
   logic        cpu_ack_q,     cpu_ack_d;
   logic        vid_ack_q,     vid_ack_d;
   logic        busy_q,        busy_d;

   // Grant decision in IDLE: video wins unless the CPU is also asking and
   // video was served last, which yields strict alternation under load.
   logic grant_vid_now;
   logic grant_cpu_now;

   // Arbitration request decode
   always_comb begin
      grant_vid_now = bus.vid_req && (!bus.cpu_req || !last_vid_q);
      grant_cpu_now = !grant_vid_now && bus.cpu_req;
   end

   // Next-state, counter, bus latch and read-data capture
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_vid_d = grant_vid_q;
      last_vid_d  = last_vid_q;
      mem_abus_d  = mem_abus_q;
      mem_page_d  = mem_page_q;
      mem_dout_d  = mem_dout_q;
      cpu_rdata_d = cpu_rdata_q;
      vid_rdata_d = vid_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (grant_vid_now) begin
               // Video is always a page-0 read; write data is left untouched.
               grant_vid_d = 1'b1;
               last_vid_d  = 1'b1;
               mem_abus_d  = bus.vid_addr;
               mem_page_d  = 3'd0;
               cnt_d       = RD_CNT_INIT;
               state_d     = S_RD;
            end else if (grant_cpu_now) begin
               // CPU request fields are captured here and ignored afterwards.
               grant_vid_d = 1'b0;
               last_vid_d  = 1'b0;
               mem_abus_d  = bus.cpu_addr;
               mem_page_d  = bus.cpu_page;
               mem_dout_d  = bus.cpu_wdata;
               if (bus.cpu_wr) begin
                  state_d = S_WR_SETUP;
               end else begin
                  cnt_d   = RD_CNT_INIT;
                  state_d = S_RD;
               end
            end
         end

         S_RD: begin
            if (cnt_q == 4'd0) begin
               if (grant_vid_q) begin
                  vid_rdata_d = bus.mem_din;
               end else begin
                  cpu_rdata_d = bus.mem_din;
               end
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         S_WR_SETUP: begin
            cnt_d   = WR_CNT_INIT;
            state_d = S_WR_STROBE;
         end

         S_WR_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = S_WR_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         S_WR_HOLD: begin
            state_d = S_DONE;
         end

         S_DONE: begin
            // No grant here: a request still held during its ack waits for IDLE.
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output flops are loaded from the next state so they line up with it
   always_comb begin
      mem_memwr_n_d = (state_d != S_WR_STROBE);
      busy_d        = (state_d != S_IDLE);
      cpu_ack_d     = (state_d == S_DONE) && !grant_vid_d;
      vid_ack_d     = (state_d == S_DONE) &&  grant_vid_d;
   end

   // State and output registers; reset drops any transaction in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= 4'd0;
         grant_vid_q   <= 1'b0;
         last_vid_q    <= 1'b0;
         mem_abus_q    <= 16'd0;
         mem_page_q    <= 3'd0;
         mem_dout_q    <= 8'd0;
         mem_memwr_n_q <= 1'b1;
         cpu_rdata_q   <= 8'd0;
         vid_rdata_q   <= 8'd0;
         cpu_ack_q     <= 1'b0;
         vid_ack_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         grant_vid_q   <= grant_vid_d;
         last_vid_q    <= last_vid_d;
         mem_abus_q    <= mem_abus_d;
         mem_page_q    <= mem_page_d;
         mem_dout_q    <= mem_dout_d;
         mem_memwr_n_q <= mem_memwr_n_d;
         cpu_rdata_q   <= cpu_rdata_d;
         vid_rdata_q   <= vid_rdata_d;
         cpu_ack_q     <= cpu_ack_d;
         vid_ack_q     <= vid_ack_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.mem_abus    = mem_abus_q;
   assign bus.mem_page    = mem_page_q;
   assign bus.mem_dout    = mem_dout_q;
   assign bus.mem_memwr_n = mem_memwr_n_q;
   assign bus.cpu_rdata   = cpu_rdata_q;
   assign bus.cpu_ack     = cpu_ack_q;
   assign bus.vid_rdata   = vid_rdata_q;
   assign bus.vid_ack     = vid_ack_q;
   assign bus.busy        = busy_q;

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, CPU read/write, one-cycle strobe,
// contention alternation, held request throughput, late input changes and
// asynchronous reset during a write strobe.
module tb_sram_arbiter;

   logic clk;
   logic reset_n;

   int tests_run = 0;
   int tests_failed = 0;

   sram_arbiter_if b2 ();   // RD_CYCLES = 2, WR_CYCLES = 2
   sram_arbiter_if b1 ();   // RD_CYCLES = 2, WR_CYCLES = 1

   sram_arbiter #(.RD_CYCLES(2), .WR_CYCLES(2)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b2)
   );

   sram_arbiter #(.RD_CYCLES(2), .WR_CYCLES(1)) u_dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   int n_acks;
   int both_ack;
   logic [0:7] wr2_exp;

   initial begin
      reset_n = 1'b0;
      b2.cpu_req = 1'b0; b2.cpu_wr = 1'b0; b2.cpu_addr = 16'h0; b2.cpu_page = 3'd0;
      b2.cpu_wdata = 8'h0; b2.vid_req = 1'b0; b2.vid_addr = 16'h0; b2.mem_din = 8'h0;
      b1.cpu_req = 1'b0; b1.cpu_wr = 1'b0; b1.cpu_addr = 16'h0; b1.cpu_page = 3'd0;
      b1.cpu_wdata = 8'h0; b1.vid_req = 1'b0; b1.vid_addr = 16'h0; b1.mem_din = 8'h0;

      // ---- Reset state ----
      nclk(2);
      chk("rst_busy",  b2.busy, 0);
      chk("rst_wr_n",  b2.mem_memwr_n, 1);
      chk("rst_abus",  b2.mem_abus, 0);
      chk("rst_page",  b2.mem_page, 0);
      chk("rst_dout",  b2.mem_dout, 0);
      chk("rst_acks",  {b2.cpu_ack, b2.vid_ack}, 0);
      chk("rst_rdata", {b2.cpu_rdata, b2.vid_rdata}, 0);
      $display("[TB] reset state checked");

      // ---- Contention from reset: V,C,V,C... ----
      b2.cpu_req = 1'b1; b2.cpu_wr = 1'b0; b2.cpu_addr = 16'hC000; b2.cpu_page = 3'd3;
      b2.vid_req = 1'b1; b2.vid_addr = 16'h0100; b2.mem_din = 8'h5A;
      reset_n = 1'b1;
      nclk(1);
      chk("cont_first_abus", b2.mem_abus, 16'h0100);
      chk("cont_first_page", b2.mem_page, 0);
      n_acks = 0;
      both_ack = 0;
      for (int c = 2; c <= 60 && n_acks < 8; c++) begin
         nclk(1);
         if (b2.cpu_ack && b2.vid_ack) both_ack++;
         if (b2.cpu_ack || b2.vid_ack) begin
            chk("cont_alt_vid", b2.vid_ack, ((n_acks % 2) == 0) ? 1 : 0);
            if (n_acks == 0) chk("cont_vid_rdata", b2.vid_rdata, 8'h5A);
            $display("[TB] contention ack %0d at cycle %0d: vid=%0b cpu=%0b",
                     n_acks, c, b2.vid_ack, b2.cpu_ack);
            n_acks++;
         end
      end
      b2.cpu_req = 1'b0; b2.vid_req = 1'b0;
      chk("cont_n_acks", n_acks, 8);
      chk("cont_no_dual_ack", both_ack, 0);
      nclk(1);
      chk("cont_idle_busy", b2.busy, 0);

      // ---- CPU read ----
      b2.cpu_req = 1'b1; b2.cpu_wr = 1'b0; b2.cpu_addr = 16'h1234; b2.cpu_page = 3'd5;
      b2.mem_din = 8'hA5;
      nclk(1);
      chk("rd_abus", b2.mem_abus, 16'h1234);
      chk("rd_page", b2.mem_page, 5);
      chk("rd_c1_ack", b2.cpu_ack, 0);
      chk("rd_c1_busy", b2.busy, 1);
      nclk(1);
      chk("rd_c2_ack", b2.cpu_ack, 0);
      nclk(1);
      chk("rd_c3_ack", b2.cpu_ack, 1);
      chk("rd_c3_rdata", b2.cpu_rdata, 8'hA5);
      chk("rd_c3_vid_ack", b2.vid_ack, 0);
      chk("rd_vid_rdata_kept", b2.vid_rdata, 8'h5A);
      b2.cpu_req = 1'b0;
      nclk(1);
      chk("rd_c4_ack", b2.cpu_ack, 0);
      chk("rd_c4_busy", b2.busy, 0);
      $display("[TB] cpu read 1234 -> %0h", b2.cpu_rdata);

      // ---- Mid-transaction address change ----
      b2.cpu_req = 1'b1; b2.cpu_addr = 16'h0010; b2.cpu_page = 3'd1;
      nclk(1);
      b2.cpu_addr = 16'h0020; b2.mem_din = 8'h77;
      nclk(1);
      chk("mid_c2_abus", b2.mem_abus, 16'h0010);
      nclk(1);
      chk("mid_c3_abus", b2.mem_abus, 16'h0010);
      chk("mid_c3_rdata", b2.cpu_rdata, 8'h77);
      b2.cpu_req = 1'b0;
      nclk(2);
      chk("mid_idle_abus", b2.mem_abus, 16'h0010);
      $display("[TB] mid-transaction change: abus held at %0h", b2.mem_abus);

      // ---- CPU write, WR_CYCLES = 2 ----
      wr2_exp = 8'b1001_1000;  // memwr_n for cycles 1..5, then padding
      b2.cpu_req = 1'b1; b2.cpu_wr = 1'b1; b2.cpu_addr = 16'h8001; b2.cpu_page = 3'd2;
      b2.cpu_wdata = 8'h3C;
      for (int c = 1; c <= 5; c++) begin
         nclk(1);
         if (c == 1) b2.cpu_wdata = 8'hFF;   // must be ignored after grant
         chk($sformatf("wr2_c%0d_wr_n", c), b2.mem_memwr_n, (c == 1 || c >= 4) ? 1 : 0);
         chk($sformatf("wr2_c%0d_dout", c), b2.mem_dout, 8'h3C);
         chk($sformatf("wr2_c%0d_ack", c), b2.cpu_ack, (c == 5) ? 1 : 0);
      end
      chk("wr2_abus", b2.mem_abus, 16'h8001);
      b2.cpu_req = 1'b0;
      nclk(1);
      chk("wr2_after_busy", b2.busy, 0);
      $display("[TB] cpu write 8001 <= 3C done, pattern ref %b", wr2_exp[0:4]);

      // ---- CPU write, WR_CYCLES = 1 ----
      b1.cpu_req = 1'b1; b1.cpu_wr = 1'b1; b1.cpu_addr = 16'h4444; b1.cpu_wdata = 8'h81;
      for (int c = 1; c <= 4; c++) begin
         nclk(1);
         chk($sformatf("wr1_c%0d_wr_n", c), b1.mem_memwr_n, (c == 2) ? 0 : 1);
         chk($sformatf("wr1_c%0d_ack", c), b1.cpu_ack, (c == 4) ? 1 : 0);
      end
      chk("wr1_dout", b1.mem_dout, 8'h81);
      b1.cpu_req = 1'b0;
      $display("[TB] cpu write 4444 <= 81 with one-cycle strobe done");

      // ---- Held CPU read: one access per 4 cycles ----
      b2.cpu_req = 1'b1; b2.cpu_wr = 1'b0; b2.cpu_addr = 16'h2000; b2.mem_din = 8'h11;
      for (int c = 1; c <= 12; c++) begin
         nclk(1);
         chk($sformatf("held_c%0d_ack", c), b2.cpu_ack, ((c % 4) == 3) ? 1 : 0);
      end
      b2.cpu_req = 1'b0;
      nclk(2);
      chk("held_end_busy", b2.busy, 0);
      $display("[TB] held cpu request serviced every 4 cycles");

      // ---- Video never writes even with cpu_wr high ----
      b2.vid_req = 1'b1; b2.vid_addr = 16'h0F00; b2.cpu_wr = 1'b1; b2.mem_din = 8'h42;
      b2.cpu_page = 3'd7;
      for (int c = 1; c <= 3; c++) begin
         nclk(1);
         chk($sformatf("vid_c%0d_wr_n", c), b2.mem_memwr_n, 1);
         chk($sformatf("vid_c%0d_ack", c), b2.vid_ack, (c == 3) ? 1 : 0);
      end
      chk("vid_page", b2.mem_page, 0);
      chk("vid_rdata", b2.vid_rdata, 8'h42);
      b2.vid_req = 1'b0; b2.cpu_wr = 1'b0;
      nclk(1);
      $display("[TB] video read 0F00 -> %0h", b2.vid_rdata);

      // ---- Async reset during WR_STROBE ----
      b2.cpu_req = 1'b1; b2.cpu_wr = 1'b1; b2.cpu_addr = 16'h5555; b2.cpu_wdata = 8'hEE;
      b2.cpu_page = 3'd4;
      nclk(2);
      chk("arst_pre_wr_n", b2.mem_memwr_n, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_wr_n", b2.mem_memwr_n, 1);
      chk("arst_busy", b2.busy, 0);
      b2.cpu_req = 1'b0; b2.cpu_wr = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         nclk(1);
         chk($sformatf("arst_c%0d_ack", c), b2.cpu_ack, 0);
      end
      reset_n = 1'b1;
      nclk(1);
      chk("arst_rel_busy",  b2.busy, 0);
      chk("arst_rel_wr_n",  b2.mem_memwr_n, 1);
      chk("arst_rel_abus",  b2.mem_abus, 0);
      chk("arst_rel_page",  b2.mem_page, 0);
      chk("arst_rel_dout",  b2.mem_dout, 0);
      chk("arst_rel_rdata", {b2.cpu_rdata, b2.vid_rdata}, 0);
      chk("arst_rel_acks",  {b2.cpu_ack, b2.vid_ack}, 0);
      $display("[TB] async reset during strobe checked");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_sram_arbiter

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Upstream sequencer for the SRAM byte-mapping stage.
- Arbitrates two byte-wide requesters onto the single byte bus that the mapping stage consumes: the CPU (read/write, with ramdisk page) and the video fetcher (read-only, page 0).
- Produces registered, glitch-free address, page, write data and write strobe, with explicit setup and hold cycles around each write strobe.
- Returns read data to each requester with a one-cycle acknowledge pulse.

Parameters:
RD_CYCLES, 2, cycles the address is held before read data is sampled (1..15).
WR_CYCLES, 2, cycles the write strobe is held low (1..15).

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU request level; held until cpu_ack, dropped or renewed after
cpu_wr  in  1  1 = write, 0 = read; valid while cpu_req
cpu_addr  in  16  CPU byte address
cpu_page  in  3  ramdisk page for CPU access
cpu_wdata  in  8  CPU write byte
cpu_rdata  out  8  CPU read byte, valid when cpu_ack, held until next CPU read completes
cpu_ack  out  1  one-cycle completion pulse
vid_req  in  1  video read request level; same protocol as cpu_req
vid_addr  in  16  video byte address
vid_rdata  out  8  video read byte, valid when vid_ack, held until next video read completes
vid_ack  out  1  one-cycle completion pulse
mem_abus  out  16  byte address to mapping stage
mem_page  out  3  ramdisk page to mapping stage
mem_dout  out  8  write byte to mapping stage
mem_memwr_n  out  1  active-low write strobe to mapping stage
mem_din  in  8  read byte from mapping stage
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n low) values:
  - state = IDLE, cnt = 0.
  - mem_memwr_n = 1 immediately (not clock-gated); mem_abus = 0, mem_page = 0, mem_dout = 0.
  - cpu_rdata = vid_rdata = 0; cpu_ack = vid_ack = 0.
  - last_grant = CPU.
  - A transaction in flight is dropped with no ack.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, RD, WR_SETUP, WR_STROBE, WR_HOLD, DONE.
- IDLE grant rule, evaluated on a rising edge:
  - Video is granted if vid_req and (!cpu_req or last_grant == CPU).
  - Otherwise CPU is granted if cpu_req.
  - Otherwise stay in IDLE.
  - With both requesters permanently requesting, grants strictly alternate.
  - On grant: latch the requester's address onto mem_abus, set last_grant. Video forces mem_page = 0; CPU drives mem_page = cpu_page and mem_dout = cpu_wdata.
- Read path (CPU with cpu_wr = 0, or any video grant):
  - IDLE -> RD with cnt = RD_CYCLES-1.
  - RD decrements cnt each cycle. When cnt == 0, sample mem_din into the granted requester's rdata and go to DONE.
- Write path (CPU with cpu_wr = 1):
  - IDLE -> WR_SETUP: one cycle, mem_memwr_n = 1, address and data stable.
  - WR_SETUP -> WR_STROBE: mem_memwr_n = 0 for exactly WR_CYCLES cycles.
  - WR_STROBE -> WR_HOLD: one cycle, mem_memwr_n = 1, address and data unchanged.
  - WR_HOLD -> DONE.
- DONE:
  - The granted requester's ack is high for exactly this cycle.
  - No grant is evaluated, so a requester still holding req during its ack cycle is not re-serviced.
  - DONE -> IDLE.
- Latency from the grant edge to ack:
  - Read: ack in cycle RD_CYCLES+1 after the grant edge.
  - Write: ack in cycle WR_CYCLES+3.
  - Back-to-back throughput: one access per (latency + 1) cycles, which includes the IDLE cycle.
- Idle bus behaviour:
  - mem_abus, mem_page and mem_dout hold their last values.
  - mem_memwr_n = 1 in every state except WR_STROBE.
- Request-input changes:
  - Requester inputs are sampled only at grant; later changes during the transaction are ignored.
  - A request dropped before grant is never serviced.
- A video request never produces a write, regardless of any other input.
- cnt is 4 bits. Parameter values outside 1..15 are illegal.

Test Plan:
- Reset: reset_n low mid-WR_STROBE -> mem_memwr_n = 1 asynchronously, no ack; after release, busy = 0 and all outputs at reset values.
- CPU read: RD_CYCLES = 2, cpu_addr = 16'h1234, cpu_page = 3'd5, mem_din = 8'hA5 -> mem_abus = 16'h1234 and mem_page = 5 from the cycle after grant; cpu_ack pulses in cycle 3 with cpu_rdata = 8'hA5; vid_ack stays 0.
- CPU write: WR_CYCLES = 2, cpu_addr = 16'h8001, cpu_wdata = 8'h3C -> mem_memwr_n pattern 1,0,0,1 over WR_SETUP/STROBE/STROBE/HOLD; mem_dout = 8'h3C throughout; cpu_ack in cycle 5; the one-cycle strobe-low case is checked with WR_CYCLES = 1.
- Contention: cpu_req and vid_req both asserted from reset -> first grant to video (mem_page = 0, vid_addr on bus); grants then alternate V,C,V,C over 8 transactions; no two acks in the same cycle.
- Held request: requester keeps req high through and after its ack, no other request -> serviced again only after the IDLE cycle that follows DONE, giving exactly one access per latency+1 cycles.
- Mid-transaction change: cpu_addr changed from 16'h0010 to 16'h0020 during RD -> mem_abus stays 16'h0010 until the next grant.
